vga_timing_generator: RTL
=========================

// Module: vga_timing_generator
// PURPOSE
//   Parametrised raster timing generator. Replaces the separate h/v counters with one block.
//   Produces coherent hsync/vsync/blank/de, pixel coordinates, line/frame strobes and a frame count.
//   Advances on a pixel clock-enable, so it runs from the system clock at any pixel rate.
//   Feeds the pixel-fetch/render path and the VGA output pins.
// PARAMETERS
//   H_VISIBLE   640  active pixels per line
//   H_FRONT     16   horizontal front porch (pixels)
//   H_SYNC      96   hsync pulse width (pixels)
//   H_BACK      48   horizontal back porch (pixels)
//   V_VISIBLE   480  active lines per frame
//   V_FRONT     10   vertical front porch (lines)
//   V_SYNC      2    vsync pulse width (lines)
//   V_BACK      33   vertical back porch (lines)
//   HSYNC_POL   0    0 = hsync active low, 1 = active high
//   VSYNC_POL   0    0 = vsync active low, 1 = active high
//   CNT_W       11   coordinate width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL)
//   FRAME_W     8    frame counter width
//   Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 x 525.
// PORTS
//   clk          in   1        system clock, all logic on posedge
//   reset_n      in   1        synchronous, active-low reset
//   pix_ce       in   1        pixel enable; counters advance only on cycles with pix_ce=1
//   run          in   1        1 = generate timing; 0 = park counters and idle outputs
//   h_count      out  CNT_W    current pixel column, 0..H_TOTAL-1
//   v_count      out  CNT_W    current line, 0..V_TOTAL-1
//   hsync        out  1        horizontal sync, polarity set by HSYNC_POL
//   vsync        out  1        vertical sync, polarity set by VSYNC_POL
//   hblank       out  1        1 when h_count >= H_VISIBLE
//   vblank       out  1        1 when v_count >= V_VISIBLE
//   de           out  1        display enable = !hblank && !vblank
//   line_start   out  1        one-clk pulse when h_count becomes 0
//   frame_start  out  1        one-clk pulse when (h_count, v_count) becomes (0,0)
//   frame_count  out  FRAME_W  completed-frame counter; increments with frame_start, wraps
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge) overrides run and pix_ce. Counters park at (H_TOTAL-1, V_TOTAL-1).
//     Reset outputs: h/v_count=0, syncs inactive (~POL), hblank=vblank=1, de=0, strobes=0, frame_count=0.
//   - Park/idle: run=0 gives the same parked counters and idle outputs as reset.
//     frame_count holds its value while parked.
//   - Advance: a cycle with run=1 and pix_ce=1 increments h. At h=H_TOTAL-1, h wraps to 0 and v increments.
//     At v=V_TOTAL-1 with h wrap, v wraps to 0.
//   - Wrap happens only on advance cycles. The parked state never wraps by itself.
//   - Run start: the first advance after parking/reset wraps to (0,0).
//     This raises line_start and frame_start and increments frame_count (0->1 after reset).
//   - All outputs are registered together from the next-state counters. Zero skew between
//     coordinates and decodes: every output describes the same (h,v), 1 clk after the advance edge.
//   - Between advance cycles all outputs hold, except line_start/frame_start,
//     which are high for exactly one clk.
//   - hsync active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
//   - vsync active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), for the whole line.
//   - run falling mid-frame: outputs go idle on the next clk and counters park.
//     There is no partial-frame recovery; the next run restarts at (0,0).
//   - frame_count wraps 2**FRAME_W-1 -> 0 silently.
// TESTING
//   1. reset_n=0 for 3 clk with run=1, pix_ce=1 -> idle outputs, frame_count=0.
//      Release -> next clk h=0, v=0, de=1, line_start=frame_start=1, frame_count=1.
//   2. Defaults, pix_ce=1 -> hsync low exactly for h=656..751; hblank=1 from h=640;
//      line_start every 800 clk.
//   3. Run to (799,524) -> next output (0,0), frame_start=1, frame_count+1;
//      vsync low for lines 490-491 only (1600 clks).
//   4. pix_ce high 1 clk in 4 -> outputs change only after ce cycles;
//      line_start/frame_start exactly 1 clk wide.
//   5. run=0 at (300,100) -> next clk idle outputs, frame_count held;
//      run=1 -> restart at (0,0) with frame_start.
//   6. Params H=8/2/2/2, V=4/1/1/1, POL=1, FRAME_W=2 -> hsync high h=10,11; vsync high v=5;
//      frame_count 3 -> 0 wrap.

Source files
------------

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: raster timing with registered, zero-skew coordinates, syncs, blanks and strobes
module vga_timing_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic               run,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);
  logic [CNT_W-1:0] h, v, h_n, v_n;
  logic fs_n;
  always_comb begin
    h_n = (h == H_LAST) ? '0 : h + 1'b1;
    v_n = (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 1'b1;
    fs_n = (h_n == '0) && (v_n == '0);
  end
  // Parking at the last position makes the first advance land on (0,0) with both strobes.
  always_ff @(posedge clk)
    if (!reset_n || !run) begin
      h <= H_LAST;
      v <= V_LAST;
      h_count <= '0;
      v_count <= '0;
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
      hblank <= 1'b1;
      vblank <= 1'b1;
      de <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      if (!reset_n) frame_count <= '0;
    end else if (pix_ce) begin
      h <= h_n;
      v <= v_n;
      h_count <= h_n;
      v_count <= v_n;
      hsync <= (int'(h_n) >= HS_BEG && int'(h_n) < HS_END) ? HS_ON : ~HS_ON;
      vsync <= (int'(v_n) >= VS_BEG && int'(v_n) < VS_END) ? VS_ON : ~VS_ON;
      hblank <= int'(h_n) >= H_VISIBLE;
      vblank <= int'(v_n) >= V_VISIBLE;
      de <= int'(h_n) < H_VISIBLE && int'(v_n) < V_VISIBLE;
      line_start <= h_n == '0;
      frame_start <= fs_n;
      frame_count <= frame_count + FRAME_W'(fs_n);
    end else begin
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end
endmodule
